// File: rtl/hit_index_serializer.sv
// Hit-vector serializer: takes a WIDTH-bit hit vector and emits the index of each
// set bit, lowest first, one beat per transfer; empty or (STRICT) multi-hit vectors emit INVALID.
module hit_index_serializer #(
  parameter int WIDTH  = 86,
  parameter int IDX_W  = 7,
  parameter bit STRICT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err,
  output logic [IDX_W-1:0] hit_count,
  output logic             dbg_state
);

  generate
    if (WIDTH < 2 || (2 ** IDX_W) - 1 < WIDTH) begin : g_param_check
      $error("hit_index_serializer: need WIDTH >= 2 and 2**IDX_W - 1 >= WIDTH");
    end
  endgenerate

  localparam logic [IDX_W-1:0] INVALID = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t             state;
  logic [WIDTH-1:0]   residue;
  logic [IDX_W-1:0]   cnt;
  logic               err;
  logic [IDX_W-1:0]   idx_q;
  logic               last_q;

  function automatic logic [IDX_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + IDX_W'(v[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lsb_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // valid never depends on ready; only in_ready looks at out_ready, for the last-beat reload.
  logic             accept;
  logic             beat;
  logic [IDX_W-1:0] in_pc;
  logic             in_err;
  logic [WIDTH-1:0] residue_clr;

  assign in_ready    = en & ((state == IDLE) | ((state == EMIT) & last_q & out_ready));
  assign accept      = in_valid & in_ready;
  assign beat        = out_valid & out_ready;
  assign in_pc       = popcnt(in_vec);
  assign in_err      = (in_pc == '0) | (STRICT & (in_pc != IDX_W'(1)));
  assign residue_clr = residue & (residue - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      residue <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      state   <= EMIT;
      residue <= in_vec;
      cnt     <= in_pc;
      err     <= in_err;
      idx_q   <= in_err ? INVALID : lsb_idx(in_vec);
      last_q  <= in_err | one_hot(in_vec);
    end else if (beat) begin
      residue <= residue_clr;
      if (last_q) begin
        state <= IDLE;
      end else begin
        idx_q  <= lsb_idx(residue_clr);
        last_q <= one_hot(residue_clr);
      end
    end
  end

  // Idle outputs read as zero; everything here is a gated register, no input path.
  assign out_valid = (state == EMIT);
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_last  = out_valid & last_q;
  assign out_err   = out_valid & err;
  assign hit_count = out_valid ? cnt : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_hit_index_serializer.sv
// Bench for hit_index_serializer: one non-strict and one strict instance, table vectors,
// directed multi-cycle sequences and a queue scoreboard checking every transferred beat.
module tb_hit_index_serializer;

  localparam int W  = 86;
  localparam int IW = 7;
  localparam int EW = 2 * IW + 2;
  localparam logic [IW-1:0] INV = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_valid_s = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in_vec = '0;

  logic          in_ready, out_valid, out_last, out_err, dbg_state;
  logic [IW-1:0] out_idx, hit_count;
  logic          in_ready_s, out_valid_s, out_last_s, out_err_s, dbg_state_s;
  logic [IW-1:0] out_idx_s, hit_count_s;

  always #5 clk = ~clk;

  hit_index_serializer #(.WIDTH(W), .IDX_W(IW), .STRICT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_err(out_err), .hit_count(hit_count), .dbg_state(dbg_state)
  );

  hit_index_serializer #(.WIDTH(W), .IDX_W(IW), .STRICT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_vec(in_vec), .out_valid(out_valid_s), .out_ready(out_ready), .out_idx(out_idx_s),
    .out_last(out_last_s), .out_err(out_err_s), .hit_count(hit_count_s), .dbg_state(dbg_state_s)
  );

  typedef struct {
    logic [W-1:0]  vec;
    bit            strict;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] hits;
    bit            err;
    int            beats;
  } vec_t;

  localparam int NT = 10;
  vec_t tbl [NT];

  logic [EW-1:0] exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  rand_ready = 1'b0;
  bit  acc_seen = 1'b0;
  bit  stall_prev = 1'b0;
  logic [2*(EW+1)-1:0] snap_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] v, input bit s);
    int pc;
    int rem;
    pc = 0;
    for (int i = 0; i < W; i++) if (v[i]) pc++;
    if (pc == 0 || (s && pc != 1)) begin
      exp_q.push_back({INV, 1'b1, 1'b1, IW'(pc)});
    end else begin
      rem = pc;
      for (int i = 0; i < W; i++) begin
        if (v[i]) begin
          rem--;
          exp_q.push_back({IW'(i), 1'(rem == 0), 1'b0, IW'(pc)});
        end
      end
    end
  endtask

  task automatic pop_cmp(input logic [EW-1:0] got, input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected beat got 0x%0h expected none at %0t", name, got, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(got), 32'(e));
    end
  endtask

  task automatic monitor();
    logic [2*(EW+1)-1:0] snap;
    acc_seen = 1'b0;
    if (!rst_n) begin
      stall_prev = 1'b0;
      return;
    end
    snap = {out_valid, out_idx, out_last, out_err, hit_count,
            out_valid_s, out_idx_s, out_last_s, out_err_s, hit_count_s};
    if (stall_prev) check("stall_hold", 32'(snap == snap_prev), 32'd1);
    check("single_active", 32'(out_valid & out_valid_s), 32'd0);
    if (out_valid && out_ready)   pop_cmp({out_idx, out_last, out_err, hit_count}, "beat");
    if (out_valid_s && out_ready) pop_cmp({out_idx_s, out_last_s, out_err_s, hit_count_s}, "beat_s");
    if (!out_valid)   check("idle_out",   32'({out_idx, out_last, out_err, hit_count}), 32'd0);
    if (!out_valid_s) check("idle_out_s", 32'({out_idx_s, out_last_s, out_err_s, hit_count_s}), 32'd0);
    if (in_valid && in_ready) begin
      push_exp(in_vec, 1'b0);
      acc_seen = 1'b1;
    end
    if (in_valid_s && in_ready_s) begin
      push_exp(in_vec, 1'b1);
      acc_seen = 1'b1;
    end
    stall_prev = (out_valid | out_valid_s) && !out_ready;
    snap_prev  = snap;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] v, input bit s);
    int n;
    in_vec = v;
    if (s) in_valid_s = 1'b1;
    else   in_valid   = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_seen && n < 1000);
    check("send_accept", 32'(acc_seen), 32'd1);
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || out_valid_s) && n < 2000) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(n < 2000), 32'd1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] bits3(input int a, input int b, input int c);
    logic [W-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    bit s;
    int n;

    tbl[0] = '{bits3(85, -1, -1), 1'b0, IW'(85), IW'(1),  1'b0, 1};
    tbl[1] = '{bits3(0, 5, 85),   1'b0, IW'(0),  IW'(3),  1'b0, 3};
    tbl[2] = '{'0,                1'b0, INV,     IW'(0),  1'b1, 1};
    tbl[3] = '{'0,                1'b1, INV,     IW'(0),  1'b1, 1};
    tbl[4] = '{bits3(3, 4, -1),   1'b1, INV,     IW'(2),  1'b1, 1};
    tbl[5] = '{bits3(3, -1, -1),  1'b1, IW'(3),  IW'(1),  1'b0, 1};
    tbl[6] = '{'1,                1'b0, IW'(0),  IW'(86), 1'b0, 86};
    tbl[7] = '{bits3(10, 20, 30), 1'b0, IW'(10), IW'(3),  1'b0, 3};
    tbl[8] = '{bits3(0, -1, -1),  1'b1, IW'(0),  IW'(1),  1'b0, 1};
    tbl[9] = '{'1,                1'b1, INV,     IW'(86), 1'b1, 1};

    // Reset values
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_outs", 32'({out_idx, out_last, out_err, hit_count}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_in_ready_en1", 32'(in_ready), 32'd1);
    en = 1'b0;
    #1;
    check("rst_in_ready_en0", 32'(in_ready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Table vectors with out_ready held high
    for (int t = 0; t < NT; t++) begin
      s = tbl[t].strict;
      send(tbl[t].vec, s);
      check("t_valid", 32'(s ? out_valid_s : out_valid), 32'd1);
      check("t_idx",   32'(s ? out_idx_s : out_idx), 32'(tbl[t].first_idx));
      check("t_err",   32'(s ? out_err_s : out_err), 32'(tbl[t].err));
      check("t_hits",  32'(s ? hit_count_s : hit_count), 32'(tbl[t].hits));
      check("t_last",  32'(s ? out_last_s : out_last), 32'(tbl[t].beats == 1));
      n = 1;
      while (!(s ? out_last_s : out_last) && n < W + 2) begin
        cycle();
        n++;
      end
      check("t_beats", 32'(n), 32'(tbl[t].beats));
    end
    drain();

    // Back-to-back reload on the last beat
    send(bits3(0, 5, 85), 1'b0);
    in_vec   = bits3(2, -1, -1);
    in_valid = 1'b1;
    check("b2b_idx0", 32'(out_idx), 32'd0);
    check("b2b_rdy0", 32'(in_ready), 32'd0);
    cycle();
    check("b2b_idx5", 32'(out_idx), 32'd5);
    check("b2b_rdy5", 32'(in_ready), 32'd0);
    cycle();
    check("b2b_idx85", 32'(out_idx), 32'd85);
    check("b2b_last85", 32'(out_last), 32'd1);
    check("b2b_rdy85", 32'(in_ready), 32'd1);
    cycle();
    check("b2b_acc", 32'(acc_seen), 32'd1);
    in_valid = 1'b0;
    check("b2b_valid2", 32'(out_valid), 32'd1);
    check("b2b_idx2", 32'(out_idx), 32'd2);
    check("b2b_hits2", 32'(hit_count), 32'd1);
    drain();

    // Backpressure while beat 20 is presented
    send(bits3(10, 20, 30), 1'b0);
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy", 32'(in_ready), 32'd0);
      cycle();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx", 32'(out_idx), 32'd20);
    end
    out_ready = 1'b1;
    drain();

    // en dropped mid-burst
    send(bits3(1, 2, 3), 1'b0);
    en       = 1'b0;
    in_vec   = bits3(9, -1, -1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("en_done", 32'(out_valid), 32'd0);
    check("en_rdy", 32'(in_ready), 32'd0);
    check("en_queue", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;
    en = 1'b1;

    // Asynchronous reset mid-burst
    send(bits3(1, 2, 3), 1'b0);
    cycle();
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_outs", 32'({out_idx, out_last, out_err, hit_count}), 32'd0);
    check("ar_rdy", 32'(in_ready), 32'd1);
    exp_q.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    check("ar_rdy_rel", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("ar_quiet", 32'(out_valid), 32'd0);
    end
    send(bits3(7, -1, -1), 1'b0);
    check("ar_idx7", 32'(out_idx), 32'd7);
    check("ar_last7", 32'(out_last), 32'd1);
    drain();

    // Random vectors with random backpressure, one instance at a time
    rand_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 15; i++) begin
        case ($urandom_range(0, 3))
          0: v = '0;
          1: begin v = '0; v[$urandom_range(0, W - 1)] = 1'b1; end
          2: v = W'({$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
                    & {$urandom, $urandom, $urandom});
          default: v = W'({$urandom, $urandom, $urandom});
        endcase
        send(v, 1'(p));
      end
      drain();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
